// File: rtl/seg_pkg.sv
// Character codes and active-low glyph patterns (seg[6:0] = g..a) shared with the
// seven-segment display driver, plus small anode-decoding helpers.
package seg_pkg;

  localparam logic [5:0] CH_F   = 6'd10;
  localparam logic [5:0] CH_A   = 6'd11;
  localparam logic [5:0] CH_I   = 6'd12;
  localparam logic [5:0] CH_L   = 6'd13;
  localparam logic [5:0] CH_SP  = 6'd14;
  localparam logic [5:0] CH_S   = 6'd15;
  localparam logic [5:0] CH_C   = 6'd16;
  localparam logic [5:0] CH_O   = 6'd17;
  localparam logic [5:0] CH_R   = 6'd18;
  localparam logic [5:0] CH_E   = 6'd19;
  localparam logic [5:0] CH_H   = 6'd20;
  localparam logic [5:0] CH_V   = 6'd21;
  localparam logic [5:0] CH_UNK = 6'd63;

  localparam logic [6:0] GLY_0     = 7'h40;
  localparam logic [6:0] GLY_1     = 7'h79;
  localparam logic [6:0] GLY_2     = 7'h24;
  localparam logic [6:0] GLY_3     = 7'h30;
  localparam logic [6:0] GLY_4     = 7'h19;
  localparam logic [6:0] GLY_5     = 7'h12;
  localparam logic [6:0] GLY_6     = 7'h02;
  localparam logic [6:0] GLY_7     = 7'h78;
  localparam logic [6:0] GLY_8     = 7'h00;
  localparam logic [6:0] GLY_9     = 7'h10;
  localparam logic [6:0] GLY_F     = 7'h0E;
  localparam logic [6:0] GLY_A     = 7'h08;
  localparam logic [6:0] GLY_I     = 7'h4F;
  localparam logic [6:0] GLY_L     = 7'h47;
  localparam logic [6:0] GLY_BLANK = 7'h7F;
  localparam logic [6:0] GLY_C     = 7'h46;
  localparam logic [6:0] GLY_R     = 7'h2F;
  localparam logic [6:0] GLY_E     = 7'h06;
  localparam logic [6:0] GLY_H     = 7'h09;
  localparam logic [6:0] GLY_V     = 7'h41;
  // S and O reuse the 5 and 0 glyphs, so a readback can only report the digit.
  localparam logic [6:0] GLY_S     = GLY_5;
  localparam logic [6:0] GLY_O     = GLY_0;

  typedef struct packed {
    logic        err;
    logic [23:0] digits;
  } frame_t;

  function automatic logic an_onehot_low(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] a);
    case (a)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational map from an active-low seven-segment pattern to a character code.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [5:0] code
);

  always_comb begin
    code = CH_UNK;
    case (seg_n)
      GLY_0:     code = 6'd0;
      GLY_1:     code = 6'd1;
      GLY_2:     code = 6'd2;
      GLY_3:     code = 6'd3;
      GLY_4:     code = 6'd4;
      GLY_5:     code = 6'd5;
      GLY_6:     code = 6'd6;
      GLY_7:     code = 6'd7;
      GLY_8:     code = 6'd8;
      GLY_9:     code = 6'd9;
      GLY_F:     code = CH_F;
      GLY_A:     code = CH_A;
      GLY_I:     code = CH_I;
      GLY_L:     code = CH_L;
      GLY_BLANK: code = CH_SP;
      GLY_C:     code = CH_C;
      GLY_R:     code = CH_R;
      GLY_E:     code = CH_E;
      GLY_H:     code = CH_H;
      GLY_V:     code = CH_V;
      default:   code = CH_UNK;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reads back a multiplexed active-low seven-segment scan bus into 4-digit frames.
// Define SEG_SCAN_SYNC_EN to put a 2-flop synchronizer in front of the dwell tracker.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [23:0] frame_digits,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic        unused_dp;
  logic [10:0] bus_s;
  assign unused_dp = seg[7];

`ifdef SEG_SCAN_SYNC_EN
  logic [10:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {an, seg[6:0]};
      sync2_q <= sync1_q;
    end
  end
  assign bus_s = sync2_q;
`else
  assign bus_s = {an, seg[6:0]};
`endif

  logic [10:0]       bus_q, bus_d;
  logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic [3:0][5:0]   slot_q, slot_d;
  logic [3:0]        got_q, got_d;
  frame_t            out_q, out_d, pend_q, pend_d, last_q, last_d, cand;
  logic              out_vld_q, out_vld_d, pend_vld_q, pend_vld_d;
  logic              have_last_q, have_last_d, overrun_q, overrun_d;
  logic              capture, complete, push, accept;
  logic [1:0]        idx;
  logic [5:0]        dec_code;

  seg_glyph_decode u_dec (
    .seg_n (bus_q[6:0]),
    .code  (dec_code)
  );

  // stable_cnt counts repeats after the first cycle of a dwell, so a dwell that has
  // lasted SETTLE_CYCLES cycles is the one that lifts it to SETTLE_CYCLES-1.
  always_comb begin
    bus_d = bus_s;
    if (bus_s != bus_q)                               stable_cnt_d = '0;
    else if (stable_cnt_q == CNT_W'(SETTLE_CYCLES))   stable_cnt_d = stable_cnt_q;
    else                                              stable_cnt_d = stable_cnt_q + 1'b1;
    capture = (bus_s == bus_q) && (stable_cnt_q == CNT_W'(SETTLE_CYCLES - 2)) &&
              an_onehot_low(bus_q[10:7]);
    idx     = an_index(bus_q[10:7]);
  end

  always_comb begin
    slot_d   = slot_q;
    got_d    = got_q;
    complete = (got_q == 4'hF);
    if (complete) got_d = '0;
    if (capture) begin
      slot_d[idx] = dec_code;
      got_d[idx]  = 1'b1;
    end
    cand.digits = slot_q;
    cand.err    = (slot_q[0] == CH_UNK) || (slot_q[1] == CH_UNK) ||
                  (slot_q[2] == CH_UNK) || (slot_q[3] == CH_UNK);
  end

  // Two-entry queue: output register backed by one pending slot that may be overwritten.
  always_comb begin
    out_d       = out_q;
    out_vld_d   = out_vld_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    overrun_d   = overrun_q;
    push        = complete && !(have_last_q && (cand == last_q));
    accept      = out_vld_q && frame_ready;
    if (push) begin
      last_d      = cand;
      have_last_d = 1'b1;
    end
    if (pend_vld_q) begin
      if (accept) begin
        out_d      = pend_q;
        pend_vld_d = push;
        if (push) pend_d = cand;
      end else if (push) begin
        pend_d    = cand;
        overrun_d = 1'b1;
      end
    end else if (out_vld_q && !accept) begin
      if (push) begin
        pend_d     = cand;
        pend_vld_d = 1'b1;
      end
    end else begin
      out_vld_d = push;
      if (push) out_d = cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q        <= '1;
      stable_cnt_q <= '0;
      slot_q       <= '0;
      got_q        <= '0;
      out_q        <= '0;
      out_vld_q    <= 1'b0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      last_q       <= '0;
      have_last_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bus_q        <= bus_d;
      stable_cnt_q <= stable_cnt_d;
      slot_q       <= slot_d;
      got_q        <= got_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      last_q       <= last_d;
      have_last_q  <= have_last_d;
      overrun_q    <= overrun_d;
    end
  end

  assign frame_valid  = out_vld_q;
  assign frame_digits = out_q.digits;
  assign frame_err    = out_q.err;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed frame table, multi-cycle corner
// sequences, and a randomized scan stream checked against a frame-level model.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_valid, frame_ready, frame_err, overrun;
  logic [23:0] frame_digits;

  int          n_checks = 0;
  int          n_fail = 0;
  int          pulses = 0;
  logic        prev_v = 1'b0;
  logic [24:0] acc_q[$];
  bit          rand_ready = 1'b0;

  logic [6:0]  gl_pat[20];
  int          gl_code[20];

  typedef struct {
    logic [7:0]  s3, s2, s1, s0;
    logic [23:0] dig;
    logic        err;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .an           (an),
    .seg          (seg),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_digits (frame_digits),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always @(negedge clk) begin
    if (rst) prev_v <= 1'b0;
    else begin
      if (frame_valid && !prev_v) pulses <= pulses + 1;
      if (frame_valid && frame_ready) acc_q.push_back({frame_err, frame_digits});
      prev_v <= frame_valid;
    end
  end

  function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
    return {a[5:0], b[5:0], c[5:0], d[5:0]};
  endfunction

  // Reference glyph lookup built from active-high gfedcba shapes.
  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    logic [5:0] r;
    r = 6'd63;
    for (int i = 0; i < 20; i++) if ((~gl_pat[i]) == s) r = 6'(gl_code[i]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_ready) frame_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) cyc();
  endtask

  task automatic scan(input logic [7:0] s3, input logic [7:0] s2, input logic [7:0] s1,
                      input logic [7:0] s0);
    dwell(4'b0111, s3, SETTLE);
    dwell(4'b1011, s2, SETTLE);
    dwell(4'b1101, s1, SETTLE);
    dwell(4'b1110, s0, SETTLE);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!frame_valid && lat < 12) begin
      cyc();
      lat++;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat, p0, base;
    logic [10:0] prev;
    int          mslot[4];
    bit          mgot[4];
    bit          mhave;
    logic [24:0] mlast, mcand;
    logic [24:0] exp_q[$];

    gl_pat  = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
                7'h71, 7'h77, 7'h30, 7'h38, 7'h00, 7'h39, 7'h50, 7'h79, 7'h76, 7'h3E};
    gl_code = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 16, 18, 19, 20, 21};

    tbl[0] = '{8'hC7, 8'hF9, 8'hC0, 8'hF8, pk(13, 1, 0, 7), 1'b0};
    tbl[1] = '{8'h80, 8'hAA, 8'hB0, 8'hA4, pk(8, 63, 3, 2), 1'b1};
    tbl[2] = '{8'h86, 8'h89, 8'h88, 8'hC6, pk(19, 20, 11, 16), 1'b0};
    tbl[3] = '{8'h92, 8'hC0, 8'h8E, 8'hCF, pk(5, 0, 10, 12), 1'b0};
    tbl[4] = '{8'h7F, 8'hC1, 8'hAF, 8'h90, pk(14, 21, 18, 9), 1'b0};
    tbl[5] = '{8'h99, 8'h82, 8'h12, 8'h80, pk(4, 6, 5, 8), 1'b0};

    rst = 1'b1; an = 4'hF; seg = 8'hFF; frame_ready = 1'b1;
    repeat (2) cyc();
    check("reset_valid", frame_valid, 0);
    check("reset_digits", frame_digits, 0);
    check("reset_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++) begin
      scan(tbl[i].s3, tbl[i].s2, tbl[i].s1, tbl[i].s0);
      wait_valid(lat);
      check($sformatf("tbl%0d_latency", i), lat, 1);
      check($sformatf("tbl%0d_digits", i), frame_digits, tbl[i].dig);
      check($sformatf("tbl%0d_err", i), frame_err, tbl[i].err);
      cyc();
      check($sformatf("tbl%0d_drop", i), frame_valid, 0);
    end

    p0 = pulses;
    repeat (5) scan(8'hC7, 8'hF9, 8'hC0, 8'hF8);
    repeat (6) cyc();
    check("repeat_pulses", pulses - p0, 1);
    check("repeat_frame", acc_q[acc_q.size()-1], {1'b0, pk(13, 1, 0, 7)});

    p0 = pulses;
    dwell(4'b0111, 8'hA4, SETTLE);
    dwell(4'b1011, 8'hB0, SETTLE);
    dwell(4'b1101, 8'h99, SETTLE);
    dwell(4'b1110, 8'h82, SETTLE - 1);
    dwell(4'hF, 8'hFF, 8);
    check("short_dwell_pulses", pulses - p0, 0);
    dwell(4'b1101, 8'h92, SETTLE);
    dwell(4'b1110, 8'h82, SETTLE);
    wait_valid(lat);
    check("recapture_valid", frame_valid, 1);
    check("recapture_digits", frame_digits, pk(2, 3, 5, 6));
    cyc();

    frame_ready = 1'b0;
    scan(8'hF8, 8'h80, 8'h90, 8'hC0);
    wait_valid(lat);
    check("ovr_first_valid", frame_valid, 1);
    check("ovr_first_digits", frame_digits, pk(7, 8, 9, 0));
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    scan(8'h82, 8'h92, 8'h99, 8'hB0);
    repeat (2) cyc();
    check("ovr_hold_valid", frame_valid, 1);
    check("ovr_hold_digits", frame_digits, pk(7, 8, 9, 0));
    check("ovr_flag", overrun, 1);
    frame_ready = 1'b1;
    cyc();
    check("ovr_next_valid", frame_valid, 1);
    check("ovr_next_digits", frame_digits, pk(6, 5, 4, 3));
    cyc();
    check("ovr_empty_valid", frame_valid, 0);
    check("ovr_sticky", overrun, 1);

    dwell(4'b1101, 8'hC0, SETTLE);
    dwell(4'b1110, 8'hF8, SETTLE);
    an = 4'hF; seg = 8'hFF; rst = 1'b1;
    cyc();
    check("midrst_valid", frame_valid, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_digits", frame_digits, 0);
    rst = 1'b0;
    cyc();
    p0 = pulses;
    dwell(4'b0111, 8'h82, SETTLE);
    dwell(4'b1011, 8'h92, SETTLE);
    dwell(4'hF, 8'hFF, 6);
    check("midrst_partial_pulses", pulses - p0, 0);
    dwell(4'b1101, 8'h99, SETTLE);
    dwell(4'b1110, 8'hB0, SETTLE);
    wait_valid(lat);
    check("midrst_fresh_valid", frame_valid, 1);
    check("midrst_fresh_digits", frame_digits, pk(6, 5, 4, 3));
    cyc();

    an = 4'hF; seg = 8'hFF; rst = 1'b1;
    cyc();
    rst = 1'b0;
    rand_ready = 1'b1;
    base = acc_q.size();
    prev = {4'hF, 7'h7F};
    mhave = 1'b0;
    for (int j = 0; j < 4; j++) begin mslot[j] = 0; mgot[j] = 1'b0; end
    for (int n = 0; n < 300; n++) begin
      logic [3:0] a;
      logic [7:0] s;
      int         len, k, g, pos;
      k = $urandom_range(0, 9);
      if (k < 8)       a = ~(4'b0001 << $urandom_range(0, 3));
      else if (k == 8) a = 4'hF;
      else             a = ~(4'b0011 << $urandom_range(0, 2));
      if ($urandom_range(0, 9) < 7) begin
        g = $urandom_range(0, 19);
        s = {1'($urandom_range(0, 1)), ~gl_pat[g]};
      end else s = 8'($urandom);
      if ({a, s[6:0]} == prev) s[0] = ~s[0];
      len = $urandom_range(1, 7);
      dwell(a, s, len);
      prev = {a, s[6:0]};
      pos = -1;
      for (int j = 0; j < 4; j++) if (a == ~(4'b0001 << j)) pos = j;
      if (len >= SETTLE && pos >= 0) begin
        mslot[pos] = ref_decode(s[6:0]);
        mgot[pos]  = 1'b1;
        if (mgot[0] && mgot[1] && mgot[2] && mgot[3]) begin
          mcand = {(mslot[0] == 63 || mslot[1] == 63 || mslot[2] == 63 || mslot[3] == 63),
                   pk(mslot[3], mslot[2], mslot[1], mslot[0])};
          for (int j = 0; j < 4; j++) mgot[j] = 1'b0;
          if (!mhave || mcand != mlast) exp_q.push_back(mcand);
          mlast = mcand;
          mhave = 1'b1;
        end
      end
    end
    an = 4'hF; seg = 8'hFF;
    repeat (40) cyc();
    rand_ready = 1'b0;
    frame_ready = 1'b1;
    check("rand_count", acc_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < acc_q.size()) check($sformatf("rand_frame%0d", i), acc_q[base+i], exp_q[i]);
    check("rand_no_overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
